// File: rtl/axi_st_patchkr_seq_ctrl.sv
// Sequences N pattern-checker runs (arm, wait first/last beat, sample, gap), tallying pass/fail/timeout per sequence.
// patchkr_en is combinational from ARM; results update on the SAMPLE/GAP edge; no backpressure, abort preempts everything.
module axi_st_patchkr_seq_ctrl #(
    parameter int RUN_W = 8,
    parameter int TO_W  = 16,
    parameter int GAP_W = 8
) (
    input  logic             rdclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [RUN_W-1:0] num_runs,
    input  logic [TO_W-1:0]  timeout_lim,
    input  logic [GAP_W-1:0] gap_lim,
    input  logic [1:0]       patchkr_out,
    input  logic             data_in_first_valid,
    input  logic             data_in_last_valid,
    input  logic             chkr_fifo_full,
    output logic             patchkr_en,
    output logic             busy,
    output logic             seq_done,
    output logic [RUN_W-1:0] pass_cnt,
    output logic [RUN_W-1:0] fail_cnt,
    output logic [RUN_W-1:0] to_cnt,
    output logic [1:0]       seq_status,
    output logic             full_seen
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT_FIRST, S_RUN, S_SAMPLE, S_GAP, S_DONE
    } state_t;

    state_t r_state, w_next;

    logic             r_start_d;
    logic [RUN_W-1:0] r_run_left;
    logic [RUN_W-1:0] r_pass_cnt, r_fail_cnt, r_to_cnt;
    logic [TO_W-1:0]  r_to_ctr;
    logic [GAP_W-1:0] r_gap_ctr;
    logic [1:0]       r_seq_status;
    logic             r_full_seen;
    logic             r_seq_done;

    logic w_start_rise, w_to_hit, w_gap_last, w_busy;
    logic w_launch, w_sample, w_to_event, w_gap_entry, w_done_entry;

    function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
        return (v == {RUN_W{1'b1}}) ? v : v + RUN_W'(1);
    endfunction

    assign w_start_rise = start & ~r_start_d;
    assign w_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_to_hit     = (timeout_lim != '0) && (r_to_ctr == timeout_lim - TO_W'(1));
    // gap_lim of 0 or 1 both give a single GAP cycle
    assign w_gap_last   = (gap_lim <= GAP_W'(1)) || (r_gap_ctr == gap_lim - GAP_W'(1));

    always_comb begin
        w_next     = r_state;
        w_launch   = 1'b0;
        w_sample   = 1'b0;
        w_to_event = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_rise) begin
                    w_next   = S_ARM;
                    w_launch = 1'b1;
                end
            end
            S_ARM: w_next = S_WAIT_FIRST;
            S_WAIT_FIRST: begin
                if (data_in_first_valid && data_in_last_valid) begin
                    w_next = S_SAMPLE;
                end else if (data_in_first_valid) begin
                    w_next = S_RUN;
                end else if (w_to_hit) begin
                    w_next     = S_GAP;
                    w_to_event = 1'b1;
                end
            end
            S_RUN: begin
                if (data_in_last_valid) begin
                    w_next = S_SAMPLE;
                end else if (w_to_hit) begin
                    w_next     = S_GAP;
                    w_to_event = 1'b1;
                end
            end
            S_SAMPLE: begin
                w_next   = S_GAP;
                w_sample = 1'b1;
            end
            S_GAP: begin
                if (w_gap_last) begin
                    w_next = (r_run_left != '0) ? S_ARM : S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next     = S_IDLE;
            w_launch   = 1'b0;
            w_sample   = 1'b0;
            w_to_event = 1'b0;
        end
    end

    assign w_gap_entry  = (w_next == S_GAP) && (r_state != S_GAP);
    assign w_done_entry = (w_next == S_DONE) && (r_state == S_GAP);

    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d    <= 1'b0;
            r_run_left   <= '0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_to_cnt     <= '0;
            r_to_ctr     <= '0;
            r_gap_ctr    <= '0;
            r_seq_status <= 2'b00;
            r_full_seen  <= 1'b0;
            r_seq_done   <= 1'b0;
        end else begin
            r_start_d  <= start;
            r_seq_done <= w_done_entry;

            if (r_state == S_ARM) begin
                r_to_ctr <= '0;
            end else if ((r_state == S_WAIT_FIRST || r_state == S_RUN) &&
                         (r_to_ctr != {TO_W{1'b1}})) begin
                r_to_ctr <= r_to_ctr + TO_W'(1);
            end

            if (w_gap_entry) begin
                r_gap_ctr <= '0;
            end else if (r_state == S_GAP && r_gap_ctr != {GAP_W{1'b1}}) begin
                r_gap_ctr <= r_gap_ctr + GAP_W'(1);
            end

            if (w_launch) begin
                r_run_left <= (num_runs == '0) ? RUN_W'(1) : num_runs;
            end else if (w_gap_entry && r_run_left != '0) begin
                r_run_left <= r_run_left - RUN_W'(1);
            end

            if (w_launch) begin
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
                r_to_cnt   <= '0;
            end else begin
                if (w_sample && patchkr_out == 2'b11) r_pass_cnt <= sat_inc(r_pass_cnt);
                if (w_sample && patchkr_out != 2'b11) r_fail_cnt <= sat_inc(r_fail_cnt);
                if (w_to_event)                       r_to_cnt   <= sat_inc(r_to_cnt);
            end

            // An abort only marks the status when it actually cuts a sequence short
            if (w_launch) begin
                r_seq_status <= 2'b00;
            end else if (abort && w_busy) begin
                r_seq_status <= 2'b11;
            end else if (w_done_entry) begin
                r_seq_status <= (r_fail_cnt == '0 && r_to_cnt == '0) ? 2'b01 : 2'b10;
            end

            if (w_launch) begin
                r_full_seen <= 1'b0;
            end else if (chkr_fifo_full && w_busy) begin
                r_full_seen <= 1'b1;
            end
        end
    end

    assign patchkr_en = (r_state == S_ARM) && !abort;
    assign busy       = w_busy;
    assign seq_done   = r_seq_done;
    assign pass_cnt   = r_pass_cnt;
    assign fail_cnt   = r_fail_cnt;
    assign to_cnt     = r_to_cnt;
    assign seq_status = r_seq_status;
    assign full_seen  = r_full_seen;

endmodule
